// File: rtl/result_writeback.sv
// result_writeback: routes each accepted ALU result to operand register A,
// operand register B, a memory write port (with ack/timeout), or nowhere
// (flags only). Keeps a completed-write counter and two sticky error flags.
module result_writeback #(
  parameter int WIDTH       = 8,
  parameter int MEM_TIMEOUT = 16   // legal range 2..255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_valid,
  input  logic [1:0]       dest,
  output logic             wb_ready,
  output logic [WIDTH-1:0] Da,
  output logic [WIDTH-1:0] Db,
  output logic             zflag,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_data,
  input  logic             mem_ack,
  output logic [7:0]       wb_count,
  output logic             drop_err,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic             dbg_state    // current FSM state: 0=IDLE, 1=MEMWR
);

  // Handshake: a request (alu_valid with alu_y/dest) is taken at a rising
  // edge only when wb_ready is high at that edge; a request presented while
  // wb_ready is low is not taken and raises drop_err. The memory side holds
  // mem_req and mem_data steady until an edge with mem_ack=1, or until the
  // wait budget runs out, whichever comes first (ack wins a tie).

  typedef enum logic {
    IDLE  = 1'b0,
    MEMWR = 1'b1
  } state_t;

  localparam logic [1:0] DEST_DA   = 2'd0;
  localparam logic [1:0] DEST_DB   = 2'd1;
  localparam logic [1:0] DEST_MEM  = 2'd2;
  localparam logic [7:0] TMO_LAST  = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] da_q, da_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic             z_q, z_d;
  logic             mem_req_q, mem_req_d;
  logic [WIDTH-1:0] mem_data_q, mem_data_d;
  logic             ready_q, ready_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             drop_q, drop_d;
  logic             tout_q, tout_d;
  logic [7:0]       tmr_q, tmr_d;

  logic             accept;
  logic             drop_ev;
  logic             tout_ev;

  // Next-state and datapath updates for both FSM states.
  always_comb begin
    state_d    = state_q;
    da_d       = da_q;
    db_d       = db_q;
    z_d        = z_q;
    mem_req_d  = mem_req_q;
    mem_data_d = mem_data_q;
    ready_d    = ready_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    tout_ev    = 1'b0;
    accept     = alu_valid & ready_q;
    drop_ev    = alu_valid & ~ready_q;

    case (state_q)
      IDLE: begin
        // mem_ack is meaningless here and deliberately not looked at.
        if (accept) begin
          z_d = (alu_y == '0);
          case (dest)
            DEST_DA: begin
              da_d  = alu_y;
              cnt_d = cnt_q + 8'd1;
            end
            DEST_DB: begin
              db_d  = alu_y;
              cnt_d = cnt_q + 8'd1;
            end
            DEST_MEM: begin
              mem_data_d = alu_y;
              mem_req_d  = 1'b1;
              ready_d    = 1'b0;
              tmr_d      = 8'd0;
              state_d    = MEMWR;
            end
            default: ;  // discard: flags only
          endcase
        end
      end
      MEMWR: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ready_d   = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          state_d   = IDLE;
        end else if (tmr_q == TMO_LAST) begin
          mem_req_d = 1'b0;
          ready_d   = 1'b1;
          tout_ev   = 1'b1;
          state_d   = IDLE;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Sticky errors: a fresh event beats a simultaneous clear.
    drop_d = drop_ev | (drop_q & ~err_clr);
    tout_d = tout_ev | (tout_q & ~err_clr);
  end

  // State register; reset dominates everything, including an open memory write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      da_q       <= '0;
      db_q       <= '0;
      z_q        <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_data_q <= '0;
      ready_q    <= 1'b1;
      cnt_q      <= 8'd0;
      drop_q     <= 1'b0;
      tout_q     <= 1'b0;
      tmr_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      da_q       <= da_d;
      db_q       <= db_d;
      z_q        <= z_d;
      mem_req_q  <= mem_req_d;
      mem_data_q <= mem_data_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      tout_q     <= tout_d;
      tmr_q      <= tmr_d;
    end
  end

  assign wb_ready    = ready_q;
  assign Da          = da_q;
  assign Db          = db_q;
  assign zflag       = z_q;
  assign mem_req     = mem_req_q;
  assign mem_data    = mem_data_q;
  assign wb_count    = cnt_q;
  assign drop_err    = drop_q;
  assign timeout_err = tout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: directed scenarios followed by random traffic, every
// cycle compared against a behavioural model of the writeback rules.
module tb_result_writeback;

  localparam int WIDTH       = 8;
  localparam int MEM_TIMEOUT = 16;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] alu_y;
  logic             alu_valid;
  logic [1:0]       dest;
  logic             wb_ready;
  logic [WIDTH-1:0] Da;
  logic [WIDTH-1:0] Db;
  logic             zflag;
  logic             mem_req;
  logic [WIDTH-1:0] mem_data;
  logic             mem_ack;
  logic [7:0]       wb_count;
  logic             drop_err;
  logic             timeout_err;
  logic             err_clr;
  logic             dbg_state;

  int n_vec;
  int n_err;

  // Model state: what the outputs should be after the latest edge.
  logic [WIDTH-1:0] m_da, m_db, m_memdata;
  logic             m_z, m_busy, m_derr, m_terr;
  logic [7:0]       m_cnt;
  int               m_age;   // cycles mem_req has been up, including this one

  result_writeback #(.WIDTH(WIDTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .alu_y(alu_y), .alu_valid(alu_valid), .dest(dest),
    .wb_ready(wb_ready), .Da(Da), .Db(Db), .zflag(zflag), .mem_req(mem_req),
    .mem_data(mem_data), .mem_ack(mem_ack), .wb_count(wb_count),
    .drop_err(drop_err), .timeout_err(timeout_err), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_da = '0; m_db = '0; m_memdata = '0; m_z = 1'b0; m_busy = 1'b0;
    m_derr = 1'b0; m_terr = 1'b0; m_cnt = 8'd0; m_age = 0;
  endtask

  // Apply the writeback rules for one rising edge with the given inputs.
  task automatic model_step(input logic v, input logic [WIDTH-1:0] y, input logic [1:0] d,
                            input logic ack, input logic clr, input logic r);
    logic drop, tout;
    if (r) begin
      model_reset();
      return;
    end
    drop = 1'b0;
    tout = 1'b0;
    if (!m_busy) begin
      if (v) begin
        m_z = (y == 0);
        if (d == 2'd0) begin m_da = y; m_cnt = m_cnt + 8'd1; end
        else if (d == 2'd1) begin m_db = y; m_cnt = m_cnt + 8'd1; end
        else if (d == 2'd2) begin m_memdata = y; m_busy = 1'b1; m_age = 1; end
      end
    end else begin
      if (v) drop = 1'b1;
      if (ack) begin
        m_busy = 1'b0; m_cnt = m_cnt + 8'd1;
      end else if (m_age >= MEM_TIMEOUT) begin
        m_busy = 1'b0; tout = 1'b1;
      end else begin
        m_age++;
      end
    end
    m_derr = drop | (m_derr & ~clr);
    m_terr = tout | (m_terr & ~clr);
  endtask

  task automatic check_all();
    check("wb_ready",    32'(wb_ready),    32'(!m_busy));
    check("Da",          32'(Da),          32'(m_da));
    check("Db",          32'(Db),          32'(m_db));
    check("zflag",       32'(zflag),       32'(m_z));
    check("mem_req",     32'(mem_req),     32'(m_busy));
    check("mem_data",    32'(mem_data),    32'(m_memdata));
    check("wb_count",    32'(wb_count),    32'(m_cnt));
    check("drop_err",    32'(drop_err),    32'(m_derr));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
  endtask

  // Driver: present inputs, take one edge, update the model, check 1 ns later.
  task automatic cyc(input logic v, input logic [WIDTH-1:0] y, input logic [1:0] d,
                     input logic ack, input logic clr, input logic r);
    alu_valid = v; alu_y = y; dest = d; mem_ack = ack; err_clr = clr; rst = r;
    @(posedge clk);
    model_step(v, y, d, ack, clr, r);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int hi;
    n_vec = 0;
    n_err = 0;
    model_reset();
    alu_valid = 0; alu_y = '0; dest = '0; mem_ack = 0; err_clr = 0; rst = 1;

    // Reset values.
    cyc(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);

    // Register write straight after reset release, then directed constants.
    cyc(1'b1, 8'h5A, 2'd0, 1'b0, 1'b0, 1'b0);
    check("da_5a", 32'(Da), 32'h5A);
    check("cnt_1", 32'(wb_count), 32'd1);
    check("db_kept", 32'(Db), 32'h0);

    // Zero result to discard: flags only.
    cyc(1'b1, 8'h00, 2'd3, 1'b0, 1'b0, 1'b0);
    check("z_discard", 32'(zflag), 32'd1);
    check("cnt_discard", 32'(wb_count), 32'd1);

    // Back-to-back register writes, ack in IDLE ignored.
    cyc(1'b1, 8'h11, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 2'd1, 1'b0, 1'b0, 1'b0);

    // Memory write acked on the 3rd cycle, with a dropped request inside.
    cyc(1'b1, 8'hC3, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 2'd0, 1'b0, 1'b0, 1'b0);
    check("drop_set", 32'(drop_err), 32'd1);
    cyc(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("memdata_c3", 32'(mem_data), 32'hC3);
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("mem_done_req", 32'(mem_req), 32'd0);
    idle(1);

    // Timeout with no ack: mem_req must stay up exactly MEM_TIMEOUT cycles.
    cyc(1'b1, 8'h9E, 2'd2, 1'b0, 1'b0, 1'b0);
    hi = 1;
    for (int i = 0; i < 40 && mem_req; i++) begin
      cyc(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
      if (mem_req) hi++;
    end
    check("tmo_len", 32'(hi), 32'(MEM_TIMEOUT));
    check("tmo_err", 32'(timeout_err), 32'd1);

    // Ack on the last possible cycle wins over the timeout.
    cyc(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h44, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < MEM_TIMEOUT; i++) cyc(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b0);
    check("late_ack_err", 32'(timeout_err), 32'd0);
    check("late_ack_rdy", 32'(wb_ready), 32'd1);

    // Counter wrap after 256 register writes from zero.
    cyc(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'($urandom), 2'd0, 1'b0, 1'b0, 1'b0);
    check("cnt_wrap", 32'(wb_count), 32'd0);

    // Clear colliding with a new drop, then clear alone.
    cyc(1'b1, 8'h01, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h02, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 2'd0, 1'b0, 1'b1, 1'b0);
    check("clr_vs_drop", 32'(drop_err), 32'd1);
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b1, 1'b0);
    check("clr_alone", 32'(drop_err), 32'd0);

    // Reset one cycle into a memory write.
    cyc(1'b1, 8'hAB, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b1);
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_cnt", 32'(wb_count), 32'd0);
    check("rst_mid_rdy", 32'(wb_ready), 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(logic'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom),
          2'($urandom), logic'($urandom_range(0, 99) < 15),
          logic'($urandom_range(0, 99) < 8), logic'($urandom_range(0, 99) < 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data width of alu_y, Da, Db and mem_data.
REQ-002 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum cycles a memory write waits for mem_ack; legal range 2..255.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high. Both ports are listed below.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 alu_y  input  WIDTH  SHALL carry the ALU result.
REQ-007 alu_valid  input  1  SHALL mark alu_y/dest as a valid request.
REQ-008 dest  input  2  SHALL select the destination: 0=Da, 1=Db, 2=memory, 3=discard (flags only).
REQ-009 wb_ready  output  1  SHALL be high when a request can be accepted.
REQ-010 Da  output  WIDTH  SHALL be operand register A, fed back to the operand selector.
REQ-011 Db  output  WIDTH  SHALL be operand register B, fed back to the operand selector.
REQ-012 zflag  output  1  SHALL be the zero flag of the last accepted result.
REQ-013 mem_req  output  1  SHALL be the memory write request, held until acknowledged or timed out.
REQ-014 mem_data  output  WIDTH  SHALL be the memory write data, stable while mem_req=1.
REQ-015 mem_ack  input  1  SHALL be the memory acknowledge, one cycle or longer.
REQ-016 wb_count  output  8  SHALL count completed writes.
REQ-017 drop_err  output  1  SHALL be the sticky error for a request presented while not ready.
REQ-018 timeout_err  output  1  SHALL be the sticky error for a memory write abort.
REQ-019 err_clr  input  1  SHALL clear both sticky errors.

Function
REQ-020 A request SHALL be accepted at a rising edge where alu_valid=1 and wb_ready=1.
REQ-021 The FSM SHALL have two states. IDLE (wb_ready=1) and MEMWR (wb_ready=0). wb_ready SHALL be a registered output.
REQ-022 On acceptance, zflag SHALL be updated to (alu_y==0) in the next cycle, for every dest value.
REQ-023 On acceptance with dest=0, Da SHALL take alu_y with 1-cycle latency, wb_count SHALL increment, and the FSM SHALL stay in IDLE.
REQ-024 On acceptance with dest=1, Db SHALL take alu_y with 1-cycle latency, wb_count SHALL increment, and the FSM SHALL stay in IDLE.
REQ-025 On acceptance with dest=3, only zflag SHALL change; wb_count SHALL not change.
REQ-026 On acceptance with dest=2: mem_data<=alu_y, mem_req<=1, wb_ready<=0, timeout counter<=0, and the FSM SHALL go to MEMWR.
REQ-027 In MEMWR with mem_ack=1 at an edge: mem_req<=0, wb_ready<=1, wb_count SHALL increment, and the FSM SHALL go to IDLE.
REQ-028 In MEMWR with mem_ack=0: the counter SHALL increment. When counter==MEM_TIMEOUT-1 and there is no ack: mem_req<=0, wb_ready<=1, timeout_err<=1, no count, and the FSM SHALL go to IDLE.
REQ-029 If mem_ack and the timeout coincide on the same edge, the ack SHALL win: the write completes and timeout_err is not set.
REQ-030 mem_ack while in IDLE SHALL be ignored.
REQ-031 alu_valid=1 while wb_ready=0 SHALL leave Da, Db, zflag and mem_data unchanged and SHALL set drop_err.
REQ-032 Requests SHALL be back-to-back acceptable in IDLE, one per cycle.
REQ-033 wb_count SHALL wrap 255->0 without any flag.
REQ-034 err_clr=1 SHALL clear drop_err and timeout_err; on the same edge, a new error event SHALL win (the flag stays 1).
REQ-035 Da, Db, zflag and wb_count SHALL change only on the events above.

Reset
REQ-036 While rst=1 at an edge: Da=0, Db=0, zflag=0, mem_req=0, mem_data=0, wb_ready=1, wb_count=0, drop_err=0, timeout_err=0, FSM=IDLE, counter=0.
REQ-037 Reset SHALL override every other input, including mid-MEMWR: mem_req SHALL drop on the next edge with no count increment and no timeout_err.
REQ-038 In the first cycle after rst deasserts, the block SHALL accept a request.

Verification
REQ-039 Reg write: alu_y=0x5A, dest=0, valid 1 cycle -> next cycle Da=0x5A, zflag=0, wb_count=1; Db unchanged.
REQ-040 Zero/discard: alu_y=0x00, dest=3 -> zflag=1; Da, Db and wb_count unchanged.
REQ-041 Mem write: alu_y=0xC3, dest=2, mem_ack on the 3rd cycle after mem_req rises -> mem_req high 3 cycles, mem_data=0xC3 throughout, wb_ready low for those cycles, wb_count+1. A second request with valid during MEMWR -> drop_err=1 and Da/Db unchanged.
REQ-042 Timeout: dest=2, mem_ack held 0, MEM_TIMEOUT=16 -> mem_req high exactly 16 cycles, then timeout_err=1, wb_ready=1, wb_count unchanged. With mem_ack on the 16th cycle instead -> completes, timeout_err=0.
REQ-043 Wrap/clear: 256 dest=0 writes -> wb_count returns to 0. err_clr together with a new drop event -> drop_err stays 1. err_clr alone -> drop_err and timeout_err become 0.
REQ-044 Reset mid-MEMWR: rst pulse 1 cycle after mem_req rises -> all outputs at reset values next cycle, wb_ready=1, and no count increment.
